// File: rtl/vram_arb_pkg.sv
// Shared types and constants for the VRAM write-port arbiter.
//
// Contents:
//   arb_state_t       arbiter FSM state encoding. The CLEAR member exists only
//                     when VRAM_ARB_CLEAR_EN is defined.
//   DROP_COUNT_WIDTH  width of the dropped-write counter.
//
// Optional feature macro: VRAM_ARB_CLEAR_EN.
package vram_arb_pkg;

  localparam int DROP_COUNT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_G = 2'd1,
    GRANT_M = 2'd2
`ifdef VRAM_ARB_CLEAR_EN
    ,
    CLEAR   = 2'd3
`endif
  } arb_state_t;

endpackage

// File: rtl/saturating_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
//
// Ports:
//   clk_i    in   clock
//   reset_i  in   synchronous, active-high reset (count returns to 0)
//   inc_i    in   add one this cycle, unless already saturated
//   clear_i  in   force the count to 0; wins over inc_i
//   count_o  out  current count
module saturating_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             inc_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/vram_write_arbiter.sv
// Owns the single VRAM write port and shares it between the game-state
// controller (G) and the mouse pixel drawer (M) through a req/gnt handshake.
// The mouse wins simultaneous requests. A requester kept waiting for
// STARVE_LIMIT cycles by the current owner takes the port over directly.
// Accepted writes reach the VRAM port one cycle later through registers.
//
// Optional feature (macro VRAM_ARB_CLEAR_EN): a clear_i pulse starts a
// non-preemptable sweep writing CLEAR_VALUE to every cell 0..PIXELS-1.
// Without the macro clear_i is ignored and busy_o stays 0.
//
// Ports:
//   clk_i, reset_i                  clock, synchronous active-high reset
//   g_req_i / m_req_i               requester wants the port
//   g_wr_en_i, g_wr_address_i,      game-state write strobe/address/data
//   g_wr_data_i
//   m_wr_en_i, m_wr_address_i,      mouse write strobe/address/data
//   m_wr_data_i
//   clear_i                         one-cycle clear request
//   g_gnt_o / m_gnt_o               registered one-hot grants
//   vram_wr_en_o, vram_wr_address_o,
//   vram_wr_data_o                  registered VRAM write port
//   busy_o                          clear sweep in progress
//   drop_count_o                    saturating count of ungranted writes
//
// State table:
//   IDLE    | nobody owns the port; arbitrate this cycle
//   GRANT_G | game-state controller owns the port
//   GRANT_M | mouse drawer owns the port
//   CLEAR   | clear sweep issuing one write per cycle (VRAM_ARB_CLEAR_EN only)
module vram_write_arbiter
  import vram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 18,
  parameter int DATA_WIDTH   = 2,
  parameter int PIXELS       = 256000,
  parameter int STARVE_LIMIT = 1024,
  parameter int CLEAR_VALUE  = 0
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        g_req_i,
  input  logic                        g_wr_en_i,
  input  logic [ADDR_WIDTH-1:0]       g_wr_address_i,
  input  logic [DATA_WIDTH-1:0]       g_wr_data_i,
  input  logic                        m_req_i,
  input  logic                        m_wr_en_i,
  input  logic [ADDR_WIDTH-1:0]       m_wr_address_i,
  input  logic [DATA_WIDTH-1:0]       m_wr_data_i,
  input  logic                        clear_i,
  output logic                        g_gnt_o,
  output logic                        m_gnt_o,
  output logic                        vram_wr_en_o,
  output logic [ADDR_WIDTH-1:0]       vram_wr_address_o,
  output logic [DATA_WIDTH-1:0]       vram_wr_data_o,
  output logic                        busy_o,
  output logic [DROP_COUNT_WIDTH-1:0] drop_count_o
);

  // Wide enough to hold STARVE_LIMIT-1, never narrower than one bit.
  localparam int STARVE_W = (STARVE_LIMIT > 2) ? $clog2(STARVE_LIMIT) : 1;
  localparam logic [STARVE_W-1:0]   STARVE_MAX = STARVE_W'(STARVE_LIMIT - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(PIXELS - 1);
  localparam logic [DATA_WIDTH-1:0] CLEAR_DATA = DATA_WIDTH'(CLEAR_VALUE);

  arb_state_t            state_q;
  arb_state_t            state_d;
  logic [STARVE_W-1:0]   starve_q;
  logic [STARVE_W-1:0]   starve_d;

  logic                  vram_wr_en_q;
  logic                  vram_wr_en_d;
  logic [ADDR_WIDTH-1:0] vram_wr_address_q;
  logic [ADDR_WIDTH-1:0] vram_wr_address_d;
  logic [DATA_WIDTH-1:0] vram_wr_data_q;
  logic [DATA_WIDTH-1:0] vram_wr_data_d;

  logic                  g_gnt;
  logic                  m_gnt;
  logic                  g_drop;
  logic                  m_drop;

`ifdef VRAM_ARB_CLEAR_EN
  logic [ADDR_WIDTH-1:0] clr_addr_q;
  logic [ADDR_WIDTH-1:0] clr_addr_d;
`else
  logic                  unused_cfg;
  assign unused_cfg = ^{clear_i, LAST_ADDR, CLEAR_DATA};
`endif

  // State register plus the registered write path.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q           <= IDLE;
      starve_q          <= '0;
      vram_wr_en_q      <= 1'b0;
      vram_wr_address_q <= '0;
      vram_wr_data_q    <= '0;
    end else begin
      state_q           <= state_d;
      starve_q          <= starve_d;
      vram_wr_en_q      <= vram_wr_en_d;
      vram_wr_address_q <= vram_wr_address_d;
      vram_wr_data_q    <= vram_wr_data_d;
    end
  end

`ifdef VRAM_ARB_CLEAR_EN
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      clr_addr_q <= '0;
    end else begin
      clr_addr_q <= clr_addr_d;
    end
  end
`endif

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    case (state_q)
      IDLE: begin
        if (m_req_i) begin
          state_d = GRANT_M;
        end else if (g_req_i) begin
          state_d = GRANT_G;
        end
      end
      GRANT_G: begin
        // A dropped request hands the port back even if M is also due.
        if (!g_req_i) begin
          state_d = IDLE;
        end else if (m_req_i) begin
          if (starve_q == STARVE_MAX) begin
            state_d = GRANT_M;
          end else begin
            starve_d = starve_q + 1'b1;
          end
        end else begin
          starve_d = '0;
        end
      end
      GRANT_M: begin
        if (!m_req_i) begin
          state_d = IDLE;
        end else if (g_req_i) begin
          if (starve_q == STARVE_MAX) begin
            state_d = GRANT_G;
          end else begin
            starve_d = starve_q + 1'b1;
          end
        end else begin
          starve_d = '0;
        end
      end
`ifdef VRAM_ARB_CLEAR_EN
      CLEAR: begin
        if (clr_addr_q == LAST_ADDR) begin
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

`ifdef VRAM_ARB_CLEAR_EN
    if (clear_i && (state_q != CLEAR)) begin
      state_d = CLEAR;
    end
`endif

    if (state_d != state_q) begin
      starve_d = '0;
    end
  end

`ifdef VRAM_ARB_CLEAR_EN
  // Sweep address restarts at 0 on every entry into CLEAR.
  always_comb begin
    clr_addr_d = '0;
    if ((state_q == CLEAR) && (state_d == CLEAR)) begin
      clr_addr_d = clr_addr_q + 1'b1;
    end
  end
`endif

  // Output logic: grants, accepted write selection and drop detection.
  always_comb begin
    g_gnt             = (state_q == GRANT_G);
    m_gnt             = (state_q == GRANT_M);
    vram_wr_en_d      = 1'b0;
    vram_wr_address_d = vram_wr_address_q;
    vram_wr_data_d    = vram_wr_data_q;

    if (g_gnt && g_wr_en_i) begin
      vram_wr_en_d      = 1'b1;
      vram_wr_address_d = g_wr_address_i;
      vram_wr_data_d    = g_wr_data_i;
    end else if (m_gnt && m_wr_en_i) begin
      vram_wr_en_d      = 1'b1;
      vram_wr_address_d = m_wr_address_i;
      vram_wr_data_d    = m_wr_data_i;
    end
`ifdef VRAM_ARB_CLEAR_EN
    else if (state_q == CLEAR) begin
      vram_wr_en_d      = 1'b1;
      vram_wr_address_d = clr_addr_q;
      vram_wr_data_d    = CLEAR_DATA;
    end
`endif

    g_drop = g_wr_en_i && !g_gnt;
    m_drop = m_wr_en_i && !m_gnt;
  end

  // Simultaneous drops from both requesters count once.
  saturating_counter #(
    .WIDTH (DROP_COUNT_WIDTH)
  ) u_drop_counter (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .inc_i   (g_drop | m_drop),
    .clear_i (1'b0),
    .count_o (drop_count_o)
  );

  assign g_gnt_o           = g_gnt;
  assign m_gnt_o           = m_gnt;
  assign vram_wr_en_o      = vram_wr_en_q;
  assign vram_wr_address_o = vram_wr_address_q;
  assign vram_wr_data_o    = vram_wr_data_q;

`ifdef VRAM_ARB_CLEAR_EN
  assign busy_o = (state_q == CLEAR);
`else
  assign busy_o = 1'b0;
`endif

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Testbench for vram_write_arbiter (small PIXELS and STARVE_LIMIT).
// Clear-sweep scenarios are compiled when VRAM_ARB_CLEAR_EN is defined.
module tb_vram_write_arbiter;

  localparam int AW     = 18;
  localparam int DW     = 2;
  localparam int PIX    = 16;
  localparam int STARVE = 8;
  localparam int CLRVAL = 0;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic          g_req_i = 1'b0;
  logic          g_wr_en_i = 1'b0;
  logic [AW-1:0] g_wr_address_i = '0;
  logic [DW-1:0] g_wr_data_i = '0;
  logic          m_req_i = 1'b0;
  logic          m_wr_en_i = 1'b0;
  logic [AW-1:0] m_wr_address_i = '0;
  logic [DW-1:0] m_wr_data_i = '0;
  logic          clear_i = 1'b0;
  logic          g_gnt_o;
  logic          m_gnt_o;
  logic          vram_wr_en_o;
  logic [AW-1:0] vram_wr_address_o;
  logic [DW-1:0] vram_wr_data_o;
  logic          busy_o;
  logic [15:0]   drop_count_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who owns the port (0 none, 1 G, 2 M, 3 clear sweep),
  // how long the other side has waited, and what the VRAM port should show.
  int            own = 0;
  int            waited = 0;
  int            clr_idx = 0;
  logic          e_wen = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_data = '0;
  int            e_drops = 0;

  vram_write_arbiter #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .PIXELS       (PIX),
    .STARVE_LIMIT (STARVE),
    .CLEAR_VALUE  (CLRVAL)
  ) dut (
    .clk_i             (clk_i),
    .reset_i           (reset_i),
    .g_req_i           (g_req_i),
    .g_wr_en_i         (g_wr_en_i),
    .g_wr_address_i    (g_wr_address_i),
    .g_wr_data_i       (g_wr_data_i),
    .m_req_i           (m_req_i),
    .m_wr_en_i         (m_wr_en_i),
    .m_wr_address_i    (m_wr_address_i),
    .m_wr_data_i       (m_wr_data_i),
    .clear_i           (clear_i),
    .g_gnt_o           (g_gnt_o),
    .m_gnt_o           (m_gnt_o),
    .vram_wr_en_o      (vram_wr_en_o),
    .vram_wr_address_o (vram_wr_address_o),
    .vram_wr_data_o    (vram_wr_data_o),
    .busy_o            (busy_o),
    .drop_count_o      (drop_count_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance the model by one clock using the inputs about to be sampled.
  task automatic model_edge();
    bit own_g;
    bit own_m;
    bit mine;
    bit other;
    int nxt;
    own_g = (own == 1);
    own_m = (own == 2);
    if (reset_i) begin
      own = 0; waited = 0; clr_idx = 0;
      e_wen = 1'b0; e_addr = '0; e_data = '0; e_drops = 0;
      return;
    end
    e_wen = 1'b0;
    if (own_g && g_wr_en_i) begin
      e_wen = 1'b1; e_addr = g_wr_address_i; e_data = g_wr_data_i;
    end else if (own_m && m_wr_en_i) begin
      e_wen = 1'b1; e_addr = m_wr_address_i; e_data = m_wr_data_i;
    end else if (own == 3) begin
      e_wen = 1'b1; e_addr = AW'(clr_idx); e_data = DW'(CLRVAL);
    end
    if (((g_wr_en_i && !own_g) || (m_wr_en_i && !own_m)) && e_drops < 65535)
      e_drops++;
    nxt = own;
    if (own == 0) begin
      nxt = m_req_i ? 2 : (g_req_i ? 1 : 0);
    end else if (own == 1 || own == 2) begin
      mine  = own_g ? g_req_i : m_req_i;
      other = own_g ? m_req_i : g_req_i;
      if (!mine) nxt = 0;
      else if (other) begin
        if (waited == STARVE - 1) nxt = 3 - own;
        else waited++;
      end else waited = 0;
    end else begin
      if (clr_idx == PIX - 1) nxt = 0;
      else clr_idx++;
    end
`ifdef VRAM_ARB_CLEAR_EN
    if (clear_i && own != 3) begin
      nxt = 3; clr_idx = 0;
    end
`endif
    if (nxt != own) waited = 0;
    own = nxt;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    g_req_i = 0; m_req_i = 0; g_wr_en_i = 0; m_wr_en_i = 0; clear_i = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_i = 1;
    tick(); tick();
    n_checks++;
    if ({g_gnt_o, m_gnt_o, vram_wr_en_o, busy_o} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got g=%b m=%b wen=%b busy=%b required 0", g_gnt_o, m_gnt_o, vram_wr_en_o, busy_o);
    end
    n_checks++;
    if ({vram_wr_address_o, vram_wr_data_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_port: got addr=%0d data=%0d required 0", vram_wr_address_o, vram_wr_data_o);
    end
    n_checks++;
    if (drop_count_o !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_drops: got %0d required 0", drop_count_o);
    end
  endtask

  task automatic test_single_g();
    reset_i = 0;
    g_req_i = 1;
    tick();                                  // cycle 1
    n_checks++;
    if ({g_gnt_o, m_gnt_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL single_g_grant: got g=%b m=%b required g=1 m=0", g_gnt_o, m_gnt_o);
    end
    tick(); tick();                          // cycle 3
    g_wr_en_i = 1; g_wr_address_i = 18'd5; g_wr_data_i = 2'd2;
    tick();                                  // cycle 4
    g_wr_en_i = 0;
    n_checks++;
    if ({vram_wr_en_o, vram_wr_address_o, vram_wr_data_o} !== {1'b1, 18'd5, 2'd2}) begin
      n_fail++;
      $display("FAIL single_g_write: got wen=%b addr=%0d data=%0d required 1/5/2", vram_wr_en_o, vram_wr_address_o, vram_wr_data_o);
    end
    tick();
    n_checks++;
    if ({vram_wr_en_o, vram_wr_address_o, vram_wr_data_o} !== {1'b0, 18'd5, 2'd2}) begin
      n_fail++;
      $display("FAIL single_g_hold: got wen=%b addr=%0d data=%0d required 0/5/2", vram_wr_en_o, vram_wr_address_o, vram_wr_data_o);
    end
    g_req_i = 0;
    tick();
    n_checks++;
    if (g_gnt_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_g_release: got g=%b required 0", g_gnt_o);
    end
  endtask

  task automatic test_priority_and_starvation();
    g_req_i = 1; m_req_i = 1;
    tick();                                  // M grant begins here
    n_checks++;
    if ({g_gnt_o, m_gnt_o} !== 2'b01) begin
      n_fail++;
      $display("FAIL priority: got g=%b m=%b required g=0 m=1", g_gnt_o, m_gnt_o);
    end
    for (int k = 1; k <= STARVE; k++) begin
      tick();
      n_checks++;
      if (k < STARVE && {g_gnt_o, m_gnt_o} !== 2'b01) begin
        n_fail++;
        $display("FAIL starve_wait k=%0d: got g=%b m=%b required g=0 m=1", k, g_gnt_o, m_gnt_o);
      end else if (k == STARVE && {g_gnt_o, m_gnt_o} !== 2'b10) begin
        n_fail++;
        $display("FAIL starve_switch: got g=%b m=%b required g=1 m=0", g_gnt_o, m_gnt_o);
      end
    end
    idle_inputs();
    tick(); tick();
  endtask

  task automatic test_drops();
    idle_inputs();
    reset_i = 1; tick(); reset_i = 0;
    for (int i = 0; i < 3; i++) begin
      m_wr_en_i = 1; tick();
      m_wr_en_i = 0; tick();
    end
    g_wr_en_i = 1; m_wr_en_i = 1; tick();
    g_wr_en_i = 0; m_wr_en_i = 0; tick();
    n_checks++;
    if (drop_count_o !== 16'd4) begin
      n_fail++;
      $display("FAIL drop_count: got %0d required 4", drop_count_o);
    end
    n_checks++;
    if (vram_wr_en_o !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_no_write: got wen=%b required 0", vram_wr_en_o);
    end
  endtask

`ifdef VRAM_ARB_CLEAR_EN
  task automatic test_clear();
    int bad;
    idle_inputs();
    g_req_i = 1;
    tick();
    clear_i = 1; tick(); clear_i = 0;         // c0: sweep issuing address 0
    bad = 0;
    for (int i = 0; i <= PIX; i++) begin
      n_checks++;
      if (busy_o !== (i < PIX) || g_gnt_o !== 1'b0 || m_gnt_o !== 1'b0 ||
          (i == 0 && vram_wr_en_o !== 1'b0) ||
          (i > 0 && {vram_wr_en_o, vram_wr_address_o, vram_wr_data_o} !== {1'b1, AW'(i - 1), DW'(CLRVAL)})) begin
        n_fail++;
        $display("FAIL clear_sweep c%0d: got busy=%b g=%b m=%b wen=%b addr=%0d data=%0d required busy=%b wen=%b addr=%0d", i, busy_o, g_gnt_o, m_gnt_o, vram_wr_en_o, vram_wr_address_o, vram_wr_data_o, (i < PIX), (i > 0), i - 1);
      end
      if (i < PIX) tick();
    end
    tick();
    n_checks++;
    if (g_gnt_o !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_regrant: got g=%b required 1", g_gnt_o);
    end
  endtask

  task automatic test_reset_mid_clear();
    idle_inputs();
    clear_i = 1; tick(); clear_i = 0;
    for (int i = 0; i < 7; i++) tick();       // sweep now issuing address 7
    reset_i = 1; tick();
    n_checks++;
    if ({g_gnt_o, m_gnt_o, vram_wr_en_o, busy_o, vram_wr_address_o, vram_wr_data_o, drop_count_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_clear: got wen=%b busy=%b addr=%0d required all 0", vram_wr_en_o, busy_o, vram_wr_address_o);
    end
    reset_i = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (vram_wr_en_o !== 1'b0 || busy_o !== 1'b0) begin
        n_fail++;
        $display("FAIL clear_after_reset: got wen=%b busy=%b required 0 0", vram_wr_en_o, busy_o);
      end
    end
  endtask
`else
  task automatic test_clear_ignored();
    idle_inputs();
    g_req_i = 1;
    tick();
    clear_i = 1; tick(); clear_i = 0;
    tick();
    n_checks++;
    if ({g_gnt_o, busy_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL clear_ignored: got g=%b busy=%b required g=1 busy=0", g_gnt_o, busy_o);
    end
    idle_inputs();
    tick();
  endtask
`endif

  task automatic test_random();
    logic [39:0] obs;
    logic [39:0] exp;
    idle_inputs();
    reset_i = 1; tick(); reset_i = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) g_req_i = ~g_req_i;
      if ($urandom_range(9) == 0) m_req_i = ~m_req_i;
      g_wr_en_i      = 1'($urandom_range(1));
      m_wr_en_i      = 1'($urandom_range(1));
      g_wr_address_i = AW'($urandom);
      m_wr_address_i = AW'($urandom);
      g_wr_data_i    = DW'($urandom);
      m_wr_data_i    = DW'($urandom);
      clear_i        = ($urandom_range(249) == 0);
      reset_i        = ($urandom_range(599) == 0);
      tick();
      obs = {g_gnt_o, m_gnt_o, vram_wr_en_o, vram_wr_address_o, vram_wr_data_o, busy_o, drop_count_o};
      exp = {own == 1, own == 2, e_wen, e_addr, e_data, own == 3, 16'(e_drops)};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL random c%0d: got %h required %h", c, obs, exp);
      end
      n_checks++;
      if (g_gnt_o && m_gnt_o) begin
        n_fail++;
        $display("FAIL onehot c%0d: got g=1 m=1 required at most one", c);
      end
    end
    reset_i = 0;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_g();
    test_priority_and_starvation();
    test_drops();
`ifdef VRAM_ARB_CLEAR_EN
    test_clear();
    test_reset_mid_clear();
`else
    test_clear_ignored();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
